// File: rtl/baud_gen_frac.sv
`timescale 1ns/1ps
// baud_gen_frac: fractional-N baud tick generator for a UART.
//   Two independent divider engines share one active configuration:
//   the rx engine emits an oversampling strobe (rxTick) every
//   rateInt + rateFrac/2^FracBits clocks; the tx engine runs the same
//   divider plus an oversample counter and emits one txTick per bit.
//   New configurations are staged as pending and applied on a tx bit
//   boundary (or immediately while disabled).
// Ports:
//   clk         clock
//   nReset      asynchronous active-low reset
//   syncReset   synchronous active-high clear, overrides everything else
//   enable      count enable
//   rateInt     clocks per rx tick, integer part (0 is treated as 1)
//   rateFrac    clocks per rx tick, fractional part (/2^FracBits)
//   osSel       oversample ratio = 2^osSel (saturates to clog2(OversampleMax))
//   rateLoad    capture rateInt/rateFrac/osSel
//   rxRestart   resynchronise the rx engine (start-bit edge)
//   rxTick      one-cycle rx sample strobe
//   txTick      one-cycle tx bit strobe
//   rateAck     one-cycle pulse when a new configuration is applied
//   ratePending captured configuration not yet applied
module baud_gen_frac #(
  parameter int unsigned MaxClockRate  = 100000000,
  parameter int unsigned MinBaudRate   = 9600,
  parameter int unsigned OversampleMax = 16,
  parameter int unsigned FracBits      = 4,
  parameter int unsigned ResetRateInt  = 651,
  parameter int unsigned ResetOsSel    = 4,
  localparam int unsigned IntWidth     = $clog2(MaxClockRate / MinBaudRate),
  localparam int unsigned OsWidth      = $clog2(OversampleMax),
  localparam int unsigned SelWidth     = $clog2(OsWidth + 1)
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                syncReset,
  input  logic                enable,
  input  logic [IntWidth-1:0] rateInt,
  input  logic [FracBits-1:0] rateFrac,
  input  logic [SelWidth-1:0] osSel,
  input  logic                rateLoad,
  input  logic                rxRestart,
  output logic                rxTick,
  output logic                txTick,
  output logic                rateAck,
  output logic                ratePending
);

  localparam logic [IntWidth-1:0] RstInt = IntWidth'(ResetRateInt);
  localparam logic [SelWidth-1:0] RstSel = SelWidth'(ResetOsSel);
  localparam logic [SelWidth-1:0] MaxSel = SelWidth'(OsWidth);

  // active and pending configuration
  logic [IntWidth-1:0] act_int, pend_int;
  logic [FracBits-1:0] act_frac, pend_frac;
  logic [SelWidth-1:0] act_sel, pend_sel;

  // divider engines
  logic [IntWidth-1:0] rx_cnt, tx_cnt;
  logic [FracBits-1:0] rx_acc, tx_acc;
  logic [OsWidth-1:0]  tx_os;

  // sanitised inputs and the configuration in force this cycle
  logic [IntWidth-1:0] in_int, cfg_int;
  logic [SelWidth-1:0] in_sel, cfg_sel;
  logic [FracBits-1:0] cfg_frac;
  logic [OsWidth-1:0]  os_reload;
  logic [FracBits:0]   rx_sum, tx_sum;
  logic                tx_wrap, apply, have_new;

  always_comb begin
    in_int   = (rateInt == '0) ? IntWidth'(1) : rateInt;
    in_sel   = (osSel > MaxSel) ? MaxSel : osSel;
    tx_wrap  = (tx_cnt == '0) && (tx_os == '0);
    apply    = enable ? tx_wrap : 1'b1;
    have_new = rateLoad || ratePending;

    // On the apply cycle the incoming (or pending) values take effect
    // immediately so that reloads in that same cycle already use them;
    // a load on the apply cycle bypasses the pending stage entirely.
    cfg_int  = act_int;
    cfg_frac = act_frac;
    cfg_sel  = act_sel;
    if (apply && rateLoad) begin
      cfg_int  = in_int;
      cfg_frac = rateFrac;
      cfg_sel  = in_sel;
    end else if (apply && ratePending) begin
      cfg_int  = pend_int;
      cfg_frac = pend_frac;
      cfg_sel  = pend_sel;
    end

    os_reload = OsWidth'((32'd1 << cfg_sel) - 32'd1);
    rx_sum    = {1'b0, rx_acc} + {1'b0, cfg_frac};
    tx_sum    = {1'b0, tx_acc} + {1'b0, cfg_frac};
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      act_int     <= RstInt;
      act_frac    <= '0;
      act_sel     <= RstSel;
      pend_int    <= '0;
      pend_frac   <= '0;
      pend_sel    <= '0;
      ratePending <= 1'b0;
      rx_cnt      <= '0;
      rx_acc      <= '0;
      tx_cnt      <= '0;
      tx_acc      <= '0;
      tx_os       <= '0;
      rxTick      <= 1'b0;
      txTick      <= 1'b0;
      rateAck     <= 1'b0;
    end else if (syncReset) begin
      act_int     <= RstInt;
      act_frac    <= '0;
      act_sel     <= RstSel;
      pend_int    <= '0;
      pend_frac   <= '0;
      pend_sel    <= '0;
      ratePending <= 1'b0;
      rx_cnt      <= '0;
      rx_acc      <= '0;
      tx_cnt      <= '0;
      tx_acc      <= '0;
      tx_os       <= '0;
      rxTick      <= 1'b0;
      txTick      <= 1'b0;
      rateAck     <= 1'b0;
    end else begin
      rxTick  <= 1'b0;
      txTick  <= 1'b0;
      rateAck <= apply && have_new;

      if (apply) begin
        act_int     <= cfg_int;
        act_frac    <= cfg_frac;
        act_sel     <= cfg_sel;
        ratePending <= 1'b0;
      end else if (rateLoad) begin
        pend_int    <= in_int;
        pend_frac   <= rateFrac;
        pend_sel    <= in_sel;
        ratePending <= 1'b1;
      end

      if (enable) begin
        rxTick <= (rx_cnt == '0) && !rxRestart;
        txTick <= tx_wrap;

        if (rxRestart) begin
          rx_cnt <= cfg_int - IntWidth'(1);
          rx_acc <= '0;
        end else if (rx_cnt == '0) begin
          rx_acc <= rx_sum[FracBits-1:0];
          rx_cnt <= cfg_int - IntWidth'(1) + IntWidth'(rx_sum[FracBits]);
        end else begin
          rx_cnt <= rx_cnt - IntWidth'(1);
        end

        if (tx_cnt == '0) begin
          tx_acc <= tx_sum[FracBits-1:0];
          tx_cnt <= cfg_int - IntWidth'(1) + IntWidth'(tx_sum[FracBits]);
          tx_os  <= (tx_os == '0) ? os_reload : tx_os - OsWidth'(1);
        end else begin
          tx_cnt <= tx_cnt - IntWidth'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
`timescale 1ns/1ps
module tb_baud_gen_frac;

  localparam int IW = $clog2(100000000 / 9600);
  localparam int FW = 4;
  localparam int SW = $clog2($clog2(16) + 1);
  localparam int HN = 1024;

  logic          clk = 1'b0;
  logic          nReset = 1'b0;
  logic          syncReset = 1'b0;
  logic          enable = 1'b0;
  logic [IW-1:0] rateInt = '0;
  logic [FW-1:0] rateFrac = '0;
  logic [SW-1:0] osSel = '0;
  logic          rateLoad = 1'b0;
  logic          rxRestart = 1'b0;
  logic          rxTick, txTick, rateAck, ratePending;

  baud_gen_frac dut (
    .clk        (clk),
    .nReset     (nReset),
    .syncReset  (syncReset),
    .enable     (enable),
    .rateInt    (rateInt),
    .rateFrac   (rateFrac),
    .osSel      (osSel),
    .rateLoad   (rateLoad),
    .rxRestart  (rxRestart),
    .rxTick     (rxTick),
    .txTick     (txTick),
    .rateAck    (rateAck),
    .ratePending(ratePending)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int c = 0;
  bit rx_h [HN];
  bit tx_h [HN];
  bit ack_h [HN];
  bit pend_h [HN];

  typedef struct {
    int ri;
    int rf;
    int rs;
    int rx0;
    int rx1;
    int tx;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic rec();
    if (c >= 0 && c < HN) begin
      rx_h[c]   = rxTick;
      tx_h[c]   = txTick;
      ack_h[c]  = rateAck;
      pend_h[c] = ratePending;
    end
  endtask

  task automatic step();
    @(negedge clk);
    c++;
    rec();
  endtask

  task automatic run_to(input int last);
    while (c < last && c < HN - 1) step();
  endtask

  // kind: 0 rx, 1 tx, 2 ack; first event strictly after 'from', -1 if none
  function automatic int next_ev(input int kind, input int from);
    if (from < 0) return -1;
    for (int i = from + 1; i <= c && i < HN; i++) begin
      if (kind == 0 && rx_h[i]) return i;
      if (kind == 1 && tx_h[i]) return i;
      if (kind == 2 && ack_h[i]) return i;
    end
    return -1;
  endfunction

  function automatic int count_pend(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi && i < HN; i++) n += int'(pend_h[i]);
    return n;
  endfunction

  task automatic load(input int ri, input int rf, input int rs);
    rateInt  = IW'(ri);
    rateFrac = FW'(rf);
    osSel    = SW'(rs);
    rateLoad = 1'b1;
  endtask

  // Reset, load a config while disabled, then enable; returns with c=0 at
  // the first enabled-cycle outputs.
  task automatic start(input int ri, input int rf, input int rs, input string tag);
    enable = 1'b0; rateLoad = 1'b0; rxRestart = 1'b0; syncReset = 1'b0;
    nReset = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_reset_outs"}, int'({rxTick, txTick, rateAck, ratePending}), 0);
    nReset = 1'b1;
    @(negedge clk);
    load(ri, rf, rs);
    @(negedge clk);
    rateLoad = 1'b0;
    chk({tag, "_ack_disabled"}, int'(rateAck), 1);
    chk({tag, "_pend_disabled"}, int'(ratePending), 0);
    @(negedge clk);
    chk({tag, "_ack_single"}, int'(rateAck), 0);
    enable = 1'b1;
    for (int i = 0; i < HN; i++) begin
      rx_h[i] = 1'b0; tx_h[i] = 1'b0; ack_h[i] = 1'b0; pend_h[i] = 1'b0;
    end
    @(negedge clk);
    c = 0;
    rec();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, r2, t1;

    // rateInt, rateFrac, osSel, rx interval 1, rx interval 2, tx interval
    tbl[0] = '{4, 0, 4, 4, 4, 64};
    tbl[1] = '{4, 8, 4, 4, 5, 72};
    tbl[2] = '{3, 0, 2, 3, 3, 12};
    tbl[3] = '{0, 0, 0, 1, 1, 1};    // rateInt 0 acts as 1, no oversampling
    tbl[4] = '{5, 4, 7, 5, 5, 84};   // osSel 7 saturates to 4
    tbl[5] = '{2, 15, 1, 2, 3, 5};

    for (int k = 0; k < 6; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      start(tbl[k].ri, tbl[k].rf, tbl[k].rs, tag);
      run_to(300);
      chk({tag, "_first_rx"}, int'(rx_h[0]), 1);
      chk({tag, "_first_tx"}, int'(tx_h[0]), 1);
      r1 = next_ev(0, 0);
      r2 = next_ev(0, r1);
      t1 = next_ev(1, 0);
      chk({tag, "_rx_int0"}, r1, tbl[k].rx0);
      chk({tag, "_rx_int1"}, (r2 < 0) ? -1 : r2 - r1, tbl[k].rx1);
      chk({tag, "_tx_int"}, t1, tbl[k].tx);
    end

    // rxRestart two cycles after an rxTick
    start(4, 0, 4, "restart");
    run_to(2);
    rxRestart = 1'b1;
    step();
    rxRestart = 1'b0;
    run_to(80);
    chk("restart_rx_next", next_ev(0, 0), 7);
    chk("restart_rx_after", next_ev(0, 7), 11);
    chk("restart_tx_kept", next_ev(1, 0), 64);

    // enable dropped for three cycles: everything holds
    start(4, 0, 4, "hold");
    run_to(1);
    enable = 1'b0;
    run_to(4);
    enable = 1'b1;
    run_to(80);
    chk("hold_rx_next", next_ev(0, 0), 7);
    chk("hold_tx_next", next_ev(1, 0), 67);

    // load mid-bit while enabled: applied at the next tx bit boundary
    start(4, 0, 4, "late");
    run_to(10);
    load(8, 0, 4);
    step();
    rateLoad = 1'b0;
    run_to(200);
    chk("late_pend_hold", count_pend(11, 63), 53);
    chk("late_ack_at", next_ev(2, 0), 64);
    chk("late_tx_at", next_ev(1, 0), 64);
    chk("late_pend_clear", int'(pend_h[64]), 0);
    chk("late_ack_once", next_ev(2, 64), -1);
    chk("late_rx_new", next_ev(0, 64), 72);
    chk("late_tx_period", next_ev(1, 64), 192);

    // two loads before the boundary: the later one wins
    start(4, 0, 4, "dbl");
    run_to(10);
    load(6, 0, 4);
    step();
    rateLoad = 1'b0;
    run_to(20);
    load(10, 0, 4);
    step();
    rateLoad = 1'b0;
    run_to(240);
    chk("dbl_ack_at", next_ev(2, 0), 64);
    chk("dbl_ack_once", next_ev(2, 64), -1);
    chk("dbl_rx_new", next_ev(0, 64), 74);
    chk("dbl_tx_period", next_ev(1, 64), 224);

    // load exactly on the apply cycle bypasses the pending stage
    start(4, 0, 4, "coin");
    run_to(63);
    load(2, 0, 4);
    step();
    rateLoad = 1'b0;
    run_to(100);
    chk("coin_ack", int'(ack_h[64]), 1);
    chk("coin_pend_never", count_pend(0, 100), 0);
    chk("coin_ack_once", next_ev(2, 64), -1);
    chk("coin_rx_new", next_ev(0, 64), 66);
    chk("coin_tx_period", next_ev(1, 64), 96);

    // syncReset with a load still pending
    start(4, 0, 4, "srst");
    run_to(10);
    load(8, 0, 4);
    step();
    rateLoad = 1'b0;
    run_to(20);
    chk("srst_pend_before", int'(pend_h[15]), 1);
    syncReset = 1'b1;
    step();
    syncReset = 1'b0;
    chk("srst_outs", int'({rx_h[21], tx_h[21], ack_h[21], pend_h[21]}), 0);
    run_to(700);
    chk("srst_no_ack", next_ev(2, 0), -1);
    chk("srst_pend_gone", count_pend(21, 700), 0);
    chk("srst_rx_first", next_ev(0, 21), 22);
    chk("srst_rx_default", next_ev(0, 22), 673);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
